// File: rtl/int_vector_ctrl_if.sv
// int_vector_ctrl_if: vector-table read port between the interrupt controller and the table memory
interface int_vector_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              vec_rd_req;
    logic [ADDR_W-1:0] vec_addr;
    logic              vec_rd_ack;
    logic [DATA_W-1:0] vec_rd_data;
    modport master (output vec_rd_req, vec_addr, input vec_rd_ack, vec_rd_data);
    modport slave (input vec_rd_req, vec_addr, output vec_rd_ack, vec_rd_data);
endinterface

// File: rtl/int_vector_ctrl.sv
// int_vector_ctrl: takes a PIC interrupt at an instruction boundary, fetches its vector and dispatches the CPU
module int_vector_ctrl #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE   = '0,
    parameter int                VEC_STRIDE = 2,
    parameter int                TIMEOUT    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              interrupt,
    input  logic [7:0]        interrupt_type,
    input  logic              ie_set,
    input  logic              ie_clr,
    input  logic              instr_boundary,
    input  logic              iret,
    int_vector_ctrl_if.master vec,
    output logic              pic_clr,
    output logic              cpu_hold,
    output logic              int_take,
    output logic [DATA_W-1:0] int_target,
    output logic              in_service,
    output logic [7:0]        cur_type,
    output logic              ie,
    output logic              vec_err
);
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic [2:0] {IDLE, WAIT_BND, RD_VEC, DISPATCH, IN_SERVICE} state_t;
    typedef struct packed {
        state_t            st;
        logic [CW-1:0]     cnt;
        logic              pic_clr;
        logic              vec_rd_req;
        logic [ADDR_W-1:0] vec_addr;
        logic              cpu_hold;
        logic              int_take;
        logic [DATA_W-1:0] int_target;
        logic              in_service;
        logic [7:0]        cur_type;
        logic              ie;
        logic              vec_err;
    } regs_t;
    regs_t r, n;
    always_ff @(posedge clock)
        if (reset) r <= '0;
        else r <= n;
    // Every output is a register; n holds the value each one takes at the next edge.
    always_comb begin
        n = r;
        n.pic_clr = 1'b0;
        n.int_take = 1'b0;
        if (!r.in_service) n.ie = ie_clr ? 1'b0 : (ie_set ? 1'b1 : r.ie);
        case (r.st)
            IDLE: if (interrupt && r.ie) n.st = WAIT_BND;
            WAIT_BND:
                if (!r.ie) n.st = IDLE;
                else if (instr_boundary) begin
                    n.st = RD_VEC;
                    n.cur_type = interrupt_type;
                    n.pic_clr = 1'b1;
                    n.cpu_hold = 1'b1;
                    n.vec_addr = VEC_BASE + ADDR_W'(interrupt_type) * ADDR_W'(VEC_STRIDE);
                    n.vec_rd_req = 1'b1;
                    n.cnt = '0;
                end
            RD_VEC:
                if (vec.vec_rd_ack) begin
                    n.st = DISPATCH;
                    n.int_target = vec.vec_rd_data;
                    n.vec_rd_req = 1'b0;
                    n.int_take = 1'b1;
                end else if (r.cnt == CW'(TIMEOUT - 1)) begin
                    n.st = IDLE;
                    n.vec_rd_req = 1'b0;
                    n.cpu_hold = 1'b0;
                    n.vec_err = 1'b1;
                end else n.cnt = r.cnt + 1'b1;
            DISPATCH: begin
                n.st = IN_SERVICE;
                n.cpu_hold = 1'b0;
                n.ie = 1'b0;
                n.in_service = 1'b1;
            end
            IN_SERVICE:
                if (iret) begin
                    n.st = IDLE;
                    n.in_service = 1'b0;
                    n.ie = 1'b1;
                end
            default: n.st = IDLE;
        endcase
    end
    assign pic_clr        = r.pic_clr;
    assign vec.vec_rd_req = r.vec_rd_req;
    assign vec.vec_addr   = r.vec_addr;
    assign cpu_hold       = r.cpu_hold;
    assign int_take       = r.int_take;
    assign int_target     = r.int_target;
    assign in_service     = r.in_service;
    assign cur_type       = r.cur_type;
    assign ie             = r.ie;
    assign vec_err        = r.vec_err;
endmodule
